// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// rv_pipe_pkg
// Shared pipeline definitions: forwarding select codes and the stage record.
// Revision: 1.0
// ============================================================================
package rv_pipe_pkg;

  localparam int RA_W_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RET   = 2'b11;

  // Reference layout at the default register-address width.
  typedef struct packed {
    logic                v;
    logic [RA_W_DEF-1:0] rd;
    logic [RA_W_DEF-1:0] rs1;
    logic [RA_W_DEF-1:0] rs2;
    logic                use1;
    logic                use2;
    logic                regwrite;
    logic                memread;
  } stage_entry_t;

  localparam int STAGE_ENTRY_W = $bits(stage_entry_t);

  function automatic int stage_entry_width(input int ra_w);
    return 3 * ra_w + 5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_sel_logic.sv
`default_nettype none
// ============================================================================
// fwd_sel_logic
// Priority compare of one EX source register against MEM, WB and RET writers.
// Revision: 1.0
// ============================================================================
module fwd_sel_logic
  import rv_pipe_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            ex_v,
  input  logic            ex_use,
  input  logic [RA_W-1:0] ex_rs,
  input  logic            mem_v,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_v,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            ret_v,
  input  logic            ret_regwrite,
  input  logic [RA_W-1:0] ret_rd,
  output logic [1:0]      sel
);

  logic w_mem_hit;
  logic w_wb_hit;
  logic w_ret_hit;

  // x0 is hard-wired zero, so a write to it never produces a forward.
  assign w_mem_hit = mem_v & mem_regwrite & (mem_rd != '0) & (mem_rd == ex_rs);
  assign w_wb_hit  = wb_v  & wb_regwrite  & (wb_rd  != '0) & (wb_rd  == ex_rs);
  assign w_ret_hit = ret_v & ret_regwrite & (ret_rd != '0) & (ret_rd == ex_rs);

  always_comb begin
    sel = FWD_RF;
    if (ex_v && ex_use) begin
      if (w_mem_hit)      sel = FWD_EXMEM;
      else if (w_wb_hit)  sel = FWD_MEMWB;
      else if (w_ret_hit) sel = FWD_RET;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// fwd_hazard_ctrl
// Shadow EX/MEM/WB/RET tracking, operand forwarding selects, load-use stall.
// Revision: 1.0
// ============================================================================
module fwd_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             lu_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            use1;
    logic            use2;
    logic            regwrite;
    logic            memread;
  } ex_entry_t;

  // Past EX only the writer identity matters.
  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            regwrite;
  } wr_entry_t;

  ex_entry_t        r_ex;
  wr_entry_t        r_mem;
  wr_entry_t        r_wb;
  wr_entry_t        r_ret;
  logic [CNT_W-1:0] r_stall_cnt;

  ex_entry_t w_id_entry;
  wr_entry_t w_ex_wr;
  logic      w_ex_load;
  logic      w_rs1_hit;
  logic      w_rs2_hit;
  logic      w_lu_stall;

  always_comb begin
    w_id_entry          = '0;
    w_id_entry.v        = id_valid;
    w_id_entry.rd       = id_rd;
    w_id_entry.rs1      = id_rs1;
    w_id_entry.rs2      = id_rs2;
    w_id_entry.use1     = id_use_rs1;
    w_id_entry.use2     = id_use_rs2;
    w_id_entry.regwrite = id_regwrite;
    w_id_entry.memread  = id_memread;
  end

  always_comb begin
    w_ex_wr          = '0;
    w_ex_wr.v        = r_ex.v;
    w_ex_wr.rd       = r_ex.rd;
    w_ex_wr.regwrite = r_ex.regwrite;
  end

  assign w_ex_load  = r_ex.v & r_ex.memread & r_ex.regwrite & (r_ex.rd != '0);
  assign w_rs1_hit  = id_use_rs1 & (id_rs1 == r_ex.rd);
  assign w_rs2_hit  = id_use_rs2 & (id_rs2 == r_ex.rd);
  // A flush kills the consumer anyway, and a hold re-evaluates next cycle.
  assign w_lu_stall = w_ex_load & id_valid & (w_rs1_hit | w_rs2_hit) & ~flush & ~hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_ret       <= '0;
      r_stall_cnt <= '0;
    end else if (!hold) begin
      r_mem <= w_ex_wr;
      r_wb  <= r_mem;
      r_ret <= r_wb;
      if (flush || w_lu_stall) begin
        r_ex <= '0;
      end else begin
        r_ex <= w_id_entry;
      end
      if (w_lu_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  fwd_sel_logic #(.RA_W(RA_W)) u_sel_a (
    .ex_v         (r_ex.v),
    .ex_use       (r_ex.use1),
    .ex_rs        (r_ex.rs1),
    .mem_v        (r_mem.v),
    .mem_regwrite (r_mem.regwrite),
    .mem_rd       (r_mem.rd),
    .wb_v         (r_wb.v),
    .wb_regwrite  (r_wb.regwrite),
    .wb_rd        (r_wb.rd),
    .ret_v        (r_ret.v),
    .ret_regwrite (r_ret.regwrite),
    .ret_rd       (r_ret.rd),
    .sel          (fwd_a_sel)
  );

  fwd_sel_logic #(.RA_W(RA_W)) u_sel_b (
    .ex_v         (r_ex.v),
    .ex_use       (r_ex.use2),
    .ex_rs        (r_ex.rs2),
    .mem_v        (r_mem.v),
    .mem_regwrite (r_mem.regwrite),
    .mem_rd       (r_mem.rd),
    .wb_v         (r_wb.v),
    .wb_regwrite  (r_wb.regwrite),
    .wb_rd        (r_wb.rd),
    .ret_v        (r_ret.v),
    .ret_regwrite (r_ret.regwrite),
    .ret_rd       (r_ret.rd),
    .sel          (fwd_b_sel)
  );

  assign lu_stall  = w_lu_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fwd_hazard_ctrl
// Directed bench for forwarding selects, load-use stalls and stall counting.
// Revision: 1.0
// ============================================================================
module tb_fwd_hazard_ctrl;

  // Narrow counter so saturation is reachable in a few hundred cycles.
  localparam int TB_CNT_W = 8;

  logic                clk;
  logic                rst;
  logic                id_valid;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [4:0]          id_rd;
  logic                id_regwrite;
  logic                id_memread;
  logic                hold;
  logic                flush;
  logic [1:0]          fwd_a_sel;
  logic [1:0]          fwd_b_sel;
  logic                lu_stall;
  logic [TB_CNT_W-1:0] stall_cnt;

  int                  errors;
  int                  checks;
  logic [TB_CNT_W-1:0] exp_cnt;

  fwd_hazard_ctrl #(.RA_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .hold        (hold),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .lu_stall    (lu_stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic rw, input logic mr);
    set_id(1'b1, rd, rs1, rs2, u1, u2, rw, mr);
    step();
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_a: got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_b: got %b want 00", fwd_b_sel); end
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL reset_lu: got %b want 0", lu_stall); end
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    drain();
    push(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);  // add x5,x1,x2
    push(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);  // sub x6,x5,x1
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL b2b_a: got %b want 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL b2b_b: got %b want 00", fwd_b_sel); end
  endtask

  task automatic test_distance();
    drain();
    push(5'd7,  5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd12, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL dist2_a: got %b want 10", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL dist2_b: got %b want 00", fwd_b_sel); end
    drain();
    push(5'd7,  5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd10, 5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd11, 5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd12, 5'd11, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL dist3_a: got %b want 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b11) begin errors++; $display("FAIL dist3_b: got %b want 11", fwd_b_sel); end
    drain();
    push(5'd7,  5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd7,  5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd12, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL newest_a: got %b want 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL newest_b: got %b want 01", fwd_b_sel); end
  endtask

  task automatic test_load_use();
    drain();
    push(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);            // lw x8
    set_id(1'b1, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);     // add x9,x8,x8
    #1;
    checks++; if (lu_stall !== 1'b1) begin errors++; $display("FAIL lu_assert: got %b want 1", lu_stall); end
    step();
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b want 0", lu_stall); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    step();
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b want 10", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd_b: got %b want 10", fwd_b_sel); end
  endtask

  task automatic test_x0();
    drain();
    push(5'd0,  5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);  // write x0
    push(5'd12, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL x0_a: got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_b: got %b want 00", fwd_b_sel); end
    drain();
    push(5'd12, 5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd13, 5'd12, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL use2off_a: got %b want 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL use2off_b: got %b want 00", fwd_b_sel); end
    drain();
    push(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);            // lw x0
    set_id(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL x0_load_stall: got %b want 0", lu_stall); end
  endtask

  task automatic test_hold();
    drain();
    push(5'd13, 5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    push(5'd14, 5'd13, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_pre_a: got %b want 01", fwd_a_sel); end
    hold = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_a[%0d]: got %b want 01", i, fwd_a_sel); end
      checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
    end
    hold = 1'b0;
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL hold_post_a: got %b want 00", fwd_a_sel); end
  endtask

  task automatic test_flush();
    drain();
    push(5'd14, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);             // lw x14
    set_id(1'b1, 5'd15, 5'd14, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x15,(x14)
    hold = 1'b1;
    #1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL hold_masks_lu: got %b want 0", lu_stall); end
    hold  = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL flush_masks_lu: got %b want 0", lu_stall); end
    step();
    flush = 1'b0;
    set_id(1'b1, 5'd16, 5'd15, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL flush_bubble_lu: got %b want 0", lu_stall); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_saturate_and_async_reset();
    drain();
    set_id(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);     // lw x8,(x8)
    step();
    for (int i = 0; i < 260; i++) begin
      step();
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (exp_cnt == 8'hFE && stall_cnt !== 8'hFE) begin
        checks++; errors++; $display("FAIL cnt_fe: got %0d want 254", stall_cnt);
      end else if (exp_cnt == 8'hFE) begin
        checks++;
      end
      step();
    end
    checks++; if (stall_cnt !== 8'hFF) begin errors++; $display("FAIL cnt_sat: got %0d want 255", stall_cnt); end
    checks++; if (lu_stall !== 1'b1) begin errors++; $display("FAIL pre_rst_lu: got %b want 1", lu_stall); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (lu_stall !== 1'b0) begin errors++; $display("FAIL arst_lu: got %b want 0", lu_stall); end
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", stall_cnt); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL arst_a: got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL arst_b: got %b want 00", fwd_b_sel); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = '0;
    rst     = 1'b1;
    hold    = 1'b0;
    flush   = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_x0();
    test_hold();
    test_flush();
    test_saturate_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
